// File: rtl/cache_data_mem_fill_pkg.sv
// Shared cache configuration: default geometry, derived line/beat widths and fill FSM states.
package cache_data_mem_fill_pkg;

  localparam int unsigned PIXEL_BITS_DEF     = 8;
  localparam int unsigned LINE_PIXELS_DEF    = 48;
  localparam int unsigned LINE_ADDR_WDTH_DEF = 7;
  localparam int unsigned FILL_BEATS_DEF     = 4;

  function automatic int unsigned line_wdth_f(int unsigned pixel_bits, int unsigned line_pixels);
    return pixel_bits * line_pixels;
  endfunction

  function automatic int unsigned beat_wdth_f(int unsigned pixel_bits, int unsigned line_pixels,
                                              int unsigned fill_beats);
    return (pixel_bits * line_pixels) / fill_beats;
  endfunction

  localparam int unsigned LINE_WDTH = line_wdth_f(PIXEL_BITS_DEF, LINE_PIXELS_DEF);
  localparam int unsigned BEAT_WDTH = beat_wdth_f(PIXEL_BITS_DEF, LINE_PIXELS_DEF, FILL_BEATS_DEF);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_COMMIT = 2'd2
  } fill_state_t;

endpackage

// File: rtl/cache_data_mem_fill_if.sv
// Read and fill handshake bundle for cache_data_mem_fill; slave side is the memory.
interface cache_data_mem_fill_if
  import cache_data_mem_fill_pkg::*;
#(
  parameter int unsigned ADDR_W = LINE_ADDR_WDTH_DEF,
  parameter int unsigned LINE_W = LINE_WDTH,
  parameter int unsigned BEAT_W = BEAT_WDTH
) ();

  logic              rd_req_in;
  logic [ADDR_W-1:0] rd_addr_in;
  logic              rd_ready_out;
  logic [LINE_W-1:0] rd_data_out;
  logic              rd_valid_out;
  logic              fill_valid_in;
  logic [ADDR_W-1:0] fill_addr_in;
  logic [BEAT_W-1:0] fill_data_in;
  logic              fill_ready_out;
  logic              fill_busy_out;

  modport master (
    output rd_req_in, rd_addr_in, fill_valid_in, fill_addr_in, fill_data_in,
    input  rd_ready_out, rd_data_out, rd_valid_out, fill_ready_out, fill_busy_out
  );

  modport slave (
    input  rd_req_in, rd_addr_in, fill_valid_in, fill_addr_in, fill_data_in,
    output rd_ready_out, rd_data_out, rd_valid_out, fill_ready_out, fill_busy_out
  );

endinterface

// File: rtl/cache_data_mem_fill_fill_buf.sv
// cache_line_fill_buf: collects FILL_BEATS beats into one line and requests a single-cycle commit.
module cache_line_fill_buf
  import cache_data_mem_fill_pkg::*;
#(
  parameter int unsigned LINE_ADDR_WDTH = LINE_ADDR_WDTH_DEF,
  parameter int unsigned BEAT_WDTH      = cache_data_mem_fill_pkg::BEAT_WDTH,
  parameter int unsigned FILL_BEATS     = FILL_BEATS_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           beat_valid,
  input  logic [LINE_ADDR_WDTH-1:0]      beat_addr,
  input  logic [BEAT_WDTH-1:0]           beat_data,
  output logic                           beat_ready,
  output logic                           busy,
  output logic                           commit,
  output logic [FILL_BEATS*BEAT_WDTH-1:0] line,
  output logic [LINE_ADDR_WDTH-1:0]      line_addr
);

  localparam int unsigned CNT_W = $clog2(FILL_BEATS + 1);

  fill_state_t                           state, state_nxt;
  logic [CNT_W-1:0]                      cnt, cnt_nxt;
  logic                                  take;
  logic [FILL_BEATS-1:0][BEAT_WDTH-1:0]  slices;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    beat_ready = 1'b0;
    take       = 1'b0;
    commit     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        beat_ready = 1'b1;
        if (beat_valid) begin
          take      = 1'b1;
          cnt_nxt   = CNT_W'(1);
          state_nxt = (FILL_BEATS == 1) ? ST_COMMIT : ST_FILL;
        end
      end
      ST_FILL: begin
        beat_ready = 1'b1;
        if (beat_valid) begin
          take    = 1'b1;
          cnt_nxt = cnt + CNT_W'(1);
          if (cnt == CNT_W'(FILL_BEATS - 1)) state_nxt = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        commit    = 1'b1;
        cnt_nxt   = '0;
        state_nxt = ST_IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // The count is 0 in IDLE, so the slice select below also covers the first beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slices    <= '0;
      line_addr <= '0;
    end else if (take) begin
      if (state == ST_IDLE) line_addr <= beat_addr;
      for (int unsigned k = 0; k < FILL_BEATS; k++) begin
        if (CNT_W'(k) == cnt) slices[k] <= beat_data;
      end
    end
  end

  assign line = slices;
  assign busy = (state != ST_IDLE);

endmodule

// File: rtl/cache_data_mem_fill.sv
// Line-wide cache data memory with beat-assembled whole-line fills and a 1-cycle read path.
// CACHE_DATA_MEM_OUT_REG_EN adds one output register stage (read latency 2).
module cache_data_mem_fill
  import cache_data_mem_fill_pkg::*;
#(
  parameter int unsigned PIXEL_BITS     = PIXEL_BITS_DEF,
  parameter int unsigned LINE_PIXELS    = LINE_PIXELS_DEF,
  parameter int unsigned LINE_ADDR_WDTH = LINE_ADDR_WDTH_DEF,
  parameter int unsigned FILL_BEATS     = FILL_BEATS_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  cache_data_mem_fill_if.slave  bus
);

  localparam int unsigned LINE_W = line_wdth_f(PIXEL_BITS, LINE_PIXELS);
  localparam int unsigned BEAT_W = beat_wdth_f(PIXEL_BITS, LINE_PIXELS, FILL_BEATS);
  localparam int unsigned DEPTH  = 1 << LINE_ADDR_WDTH;

  logic                      commit;
  logic                      fill_ready;
  logic                      fill_busy;
  logic [LINE_W-1:0]         wr_line;
  logic [LINE_ADDR_WDTH-1:0] wr_addr;
  logic                      rd_ready;
  logic                      rd_take;
  logic                      rd_valid_q;
  logic [LINE_W-1:0]         rd_data_q;
  logic [LINE_W-1:0]         mem [DEPTH];

  cache_line_fill_buf #(
    .LINE_ADDR_WDTH (LINE_ADDR_WDTH),
    .BEAT_WDTH      (BEAT_W),
    .FILL_BEATS     (FILL_BEATS)
  ) u_fill_buf (
    .clk        (clk),
    .rst_n      (reset_n),
    .beat_valid (bus.fill_valid_in),
    .beat_addr  (bus.fill_addr_in),
    .beat_data  (bus.fill_data_in),
    .beat_ready (fill_ready),
    .busy       (fill_busy),
    .commit     (commit),
    .line       (wr_line),
    .line_addr  (wr_addr)
  );

  assign bus.fill_ready_out = fill_ready;
  assign bus.fill_busy_out  = fill_busy;

  // Reads are refused during COMMIT, so the array never sees a read and write together.
  assign rd_ready         = !commit;
  assign rd_take          = bus.rd_req_in && rd_ready;
  assign bus.rd_ready_out = rd_ready;

  always_ff @(posedge clk) begin
    if (commit) mem[wr_addr] <= wr_line;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_take;
      if (rd_take) rd_data_q <= mem[bus.rd_addr_in];
    end
  end

`ifdef CACHE_DATA_MEM_OUT_REG_EN
  logic              rd_valid_q2;
  logic [LINE_W-1:0] rd_data_q2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid_q2 <= 1'b0;
      rd_data_q2  <= '0;
    end else begin
      rd_valid_q2 <= rd_valid_q;
      if (rd_valid_q) rd_data_q2 <= rd_data_q;
    end
  end

  assign bus.rd_valid_out = rd_valid_q2;
  assign bus.rd_data_out  = rd_data_q2;
`else
  assign bus.rd_valid_out = rd_valid_q;
  assign bus.rd_data_out  = rd_data_q;
`endif

endmodule

// File: tb/tb_cache_data_mem_fill.sv
// Randomized bench for cache_data_mem_fill against a line-level memory/fill model.
module tb_cache_data_mem_fill;
  import cache_data_mem_fill_pkg::*;

  localparam int unsigned LW    = LINE_WDTH;
  localparam int unsigned BW    = BEAT_WDTH;
  localparam int unsigned AW    = LINE_ADDR_WDTH_DEF;
  localparam int unsigned NB    = FILL_BEATS_DEF;
  localparam int unsigned DEPTH = 1 << AW;
`ifdef CACHE_DATA_MEM_OUT_REG_EN
  localparam int unsigned LAT = 2;
`else
  localparam int unsigned LAT = 1;
`endif

  typedef logic [LW-1:0] line_t;
  typedef logic [BW-1:0] beat_t;
  typedef struct {
    int unsigned due;
    line_t       data;
  } rd_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  cache_data_mem_fill_if #(.ADDR_W(AW), .LINE_W(LW), .BEAT_W(BW)) bus ();
  cache_data_mem_fill_if #(.ADDR_W(2), .LINE_W(32), .BEAT_W(32)) bus1 ();

  cache_data_mem_fill #(
    .PIXEL_BITS(8), .LINE_PIXELS(48), .LINE_ADDR_WDTH(AW), .FILL_BEATS(NB)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave)
  );

  cache_data_mem_fill #(
    .PIXEL_BITS(8), .LINE_PIXELS(4), .LINE_ADDR_WDTH(2), .FILL_BEATS(1)
  ) u_dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1.slave)
  );

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic check(input string name, input line_t act, input line_t exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // Reference model: line array, queue of beats of the fill in flight, pending read results.
  line_t       mem_m [DEPTH];
  beat_t       fq[$];
  logic [AW-1:0] faddr;
  bit          commit_next = 1'b0;
  rd_t         rq[$];
  int unsigned cyc = 0;
  line_t       last_data = '0;
  line_t       asm_line;
  bit          ev;
  line_t       ed;

  always @(posedge clk) begin
    if (!reset_n) begin
      fq.delete();
      rq.delete();
      commit_next = 1'b0;
      last_data   = '0;
    end else begin
      cyc++;
      if (bus.rd_req_in && !commit_next) rq.push_back('{cyc + LAT - 1, mem_m[bus.rd_addr_in]});
      if (commit_next) begin
        asm_line = '0;
        for (int k = 0; k < NB; k++) asm_line[k*BW +: BW] = fq[k];
        mem_m[faddr] = asm_line;
        fq.delete();
        commit_next = 1'b0;
      end else if (bus.fill_valid_in) begin
        if (fq.size() == 0) faddr = bus.fill_addr_in;
        fq.push_back(bus.fill_data_in);
        if (fq.size() == NB) commit_next = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      check("rst_rd_valid", LW'(bus.rd_valid_out), '0);
      check("rst_rd_data", bus.rd_data_out, '0);
      check("rst_fill_busy", LW'(bus.fill_busy_out), '0);
      check("rst_fill_ready", LW'(bus.fill_ready_out), LW'(1));
    end else begin
      if (rq.size() > 0 && rq[0].due == cyc) begin
        ev = 1'b1;
        ed = rq[0].data;
        last_data = ed;
        void'(rq.pop_front());
      end else begin
        ev = 1'b0;
        ed = last_data;
      end
      check("rd_valid", LW'(bus.rd_valid_out), LW'(ev));
      check("rd_data", bus.rd_data_out, ed);
      check("rd_ready", LW'(bus.rd_ready_out), LW'(!commit_next));
      check("fill_ready", LW'(bus.fill_ready_out), LW'(!commit_next));
      check("fill_busy", LW'(bus.fill_busy_out), LW'((fq.size() > 0) || commit_next));
    end
  end

  function automatic line_t pre_line(input int unsigned a);
    logic [7:0] b;
    b = 8'(a) ^ 8'hA5;
    return {(LW/8){b}};
  endfunction

  function automatic line_t rand_line();
    line_t l;
    for (int i = 0; i < LW; i++) l[i] = 1'($urandom);
    return l;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [AW-1:0] a, input beat_t d);
    int unsigned n;
    n = 0;
    bus.fill_valid_in = 1'b1;
    bus.fill_addr_in  = a;
    bus.fill_data_in  = d;
    while (!bus.fill_ready_out && n < 8) begin
      tick();
      n++;
    end
    if (n >= 8) check("fill_ready_timeout", LW'(bus.fill_ready_out), LW'(1));
    tick();
  endtask

  task automatic send_line(input logic [AW-1:0] a, input line_t l);
    for (int k = 0; k < NB; k++) send_beat(a, l[k*BW +: BW]);
    bus.fill_valid_in = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, output line_t d);
    int unsigned n;
    n = 0;
    bus.rd_req_in  = 1'b1;
    bus.rd_addr_in = a;
    while (!bus.rd_ready_out && n < 8) begin
      tick();
      n++;
    end
    if (n >= 8) check("rd_ready_timeout", LW'(bus.rd_ready_out), LW'(1));
    tick();
    bus.rd_req_in = 1'b0;
    repeat (LAT - 1) tick();
    check("read_valid_latency", LW'(bus.rd_valid_out), LW'(1));
    d = bus.rd_data_out;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before the bench completed");
    $fatal(1);
  end

  initial begin
    line_t d;
    line_t l5;
    line_t n9;
    line_t n3;
    int unsigned taken;
    int j;

    bus.rd_req_in = 1'b0;     bus.rd_addr_in = '0;
    bus.fill_valid_in = 1'b0; bus.fill_addr_in = '0; bus.fill_data_in = '0;
    bus1.rd_req_in = 1'b0;    bus1.rd_addr_in = '0;
    bus1.fill_valid_in = 1'b0; bus1.fill_addr_in = '0; bus1.fill_data_in = '0;

    repeat (3) tick();
    check("reset_rd_data", bus.rd_data_out, '0);
    check("reset_rd_valid", LW'(bus.rd_valid_out), '0);
    check("reset_busy", LW'(bus.fill_busy_out), '0);
    reset_n = 1'b1;
    tick();

    for (int a = 0; a < DEPTH; a++) send_line(AW'(a), pre_line(a));
    tick();

    // Four distinct beats to line 5, then read back.
    l5 = {{12{8'h44}}, {12{8'h33}}, {12{8'h22}}, {12{8'h11}}};
    send_beat(AW'(5), {12{8'h11}});
    send_beat(AW'(5), {12{8'h22}});
    send_beat(AW'(5), {12{8'h33}});
    send_beat(AW'(5), {12{8'h44}});
    bus.fill_valid_in = 1'b0;
    tick();
    do_read(AW'(5), d);
    check("line5_data", d, l5);
    check("line5_model", mem_m[5], l5);

    // Gapped fill of line 9 with reads before and across its commit.
    n9 = rand_line();
    for (int k = 0; k < NB; k++) begin
      send_beat(AW'(9), n9[k*BW +: BW]);
      bus.fill_valid_in = 1'b0;
      if (k < NB - 1) begin
        repeat (3) begin
          check("busy_in_gap", LW'(bus.fill_busy_out), LW'(1));
          tick();
        end
        if (k == 1) begin
          do_read(AW'(9), d);
          check("read9_old", d, pre_line(9));
        end
      end
    end
    bus.rd_req_in  = 1'b1;
    bus.rd_addr_in = AW'(9);
    check("rd_ready_in_commit", LW'(bus.rd_ready_out), '0);
    check("fill_ready_in_commit", LW'(bus.fill_ready_out), '0);
    check("busy_in_commit", LW'(bus.fill_busy_out), LW'(1));
    tick();
    check("rd_ready_after_commit", LW'(bus.rd_ready_out), LW'(1));
    tick();
    bus.rd_req_in = 1'b0;
    repeat (LAT - 1) tick();
    check("read9_new_valid", LW'(bus.rd_valid_out), LW'(1));
    check("read9_new", bus.rd_data_out, n9);

    // Reset in the middle of a fill to line 3.
    n3 = rand_line();
    send_beat(AW'(3), n3[0 +: BW]);
    send_beat(AW'(3), n3[BW +: BW]);
    bus.fill_valid_in = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("busy_after_reset", LW'(bus.fill_busy_out), '0);
    check("fill_ready_after_reset", LW'(bus.fill_ready_out), LW'(1));
    do_read(AW'(3), d);
    check("read3_unchanged", d, pre_line(3));
    send_line(AW'(3), n3);
    tick();
    do_read(AW'(3), d);
    check("read3_refill", d, n3);

    // Back-to-back reads of lines 0..7.
    for (int i = 0; i < 8 + LAT - 1; i++) begin
      if (i < 8) begin
        bus.rd_req_in  = 1'b1;
        bus.rd_addr_in = AW'(i);
      end else begin
        bus.rd_req_in = 1'b0;
      end
      tick();
      if (i >= LAT - 1) begin
        j = i - (LAT - 1);
        check("b2b_valid", LW'(bus.rd_valid_out), LW'(1));
        check("b2b_data", bus.rd_data_out, mem_m[j]);
      end
    end
    bus.rd_req_in = 1'b0;
    tick();
    check("b2b_end_valid", LW'(bus.rd_valid_out), '0);

    // Random traffic on both ports.
    repeat (3000) begin
      bus.rd_req_in     = 1'($urandom_range(0, 1));
      bus.rd_addr_in    = AW'($urandom);
      bus.fill_valid_in = ($urandom_range(0, 9) < 6);
      bus.fill_addr_in  = AW'($urandom);
      for (int i = 0; i < BW; i++) bus.fill_data_in[i] = 1'($urandom);
      tick();
    end
    bus.rd_req_in = 1'b0;
    bus.fill_valid_in = 1'b0;
    repeat (10) tick();

    // Single-beat fills with valid held high: one beat every other cycle.
    taken = 0;
    for (int i = 0; i < 10; i++) begin
      bus1.fill_valid_in = 1'b1;
      bus1.fill_addr_in  = 2'd1;
      bus1.fill_data_in  = 32'hC0DE0000 + 32'(i);
      check("fb1_ready", LW'(bus1.fill_ready_out), LW'(i % 2 == 0));
      if (bus1.fill_ready_out) taken++;
      tick();
    end
    bus1.fill_valid_in = 1'b0;
    check("fb1_taken", LW'(taken), LW'(5));
    bus1.rd_req_in  = 1'b1;
    bus1.rd_addr_in = 2'd1;
    tick();
    bus1.rd_req_in = 1'b0;
    repeat (LAT - 1) tick();
    check("fb1_valid", LW'(bus1.rd_valid_out), LW'(1));
    check("fb1_data", LW'(bus1.rd_data_out), LW'(32'hC0DE0008));

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cache_data_mem_fill.md
CACHE_DATA_MEM_FILL -- requirements
Module: cache_data_mem_fill

Interface
REQ-001 SHALL have parameter PIXEL_BITS, default 8, bits per pixel.
REQ-002 SHALL have parameter LINE_PIXELS, default 48, pixels per cache line; LINE_WDTH = PIXEL_BITS*LINE_PIXELS.
REQ-003 SHALL have parameter LINE_ADDR_WDTH, default 7, line-address width; depth = 2^LINE_ADDR_WDTH lines.
REQ-004 SHALL have parameter FILL_BEATS, default 4, beats per line fill; FILL_BEATS SHALL divide LINE_PIXELS; BEAT_WDTH = LINE_WDTH/FILL_BEATS.
REQ-005 SHALL have one clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  clock; all state is updated on its rising edge.
REQ-007 reset_n  input  1  asynchronous active-low reset.
REQ-008 rd_req_in  input  1  read request.
REQ-009 rd_addr_in  input  LINE_ADDR_WDTH  read line address.
REQ-010 rd_ready_out  output  1  read accept; a read is taken when rd_req_in && rd_ready_out.
REQ-011 rd_data_out  output  LINE_WDTH  read line data.
REQ-012 rd_valid_out  output  1  rd_data_out valid, one pulse per accepted read.
REQ-013 fill_valid_in  input  1  fill beat valid.
REQ-014 fill_addr_in  input  LINE_ADDR_WDTH  fill line address, sampled on the first beat only.
REQ-015 fill_data_in  input  BEAT_WDTH  fill beat data.
REQ-016 fill_ready_out  output  1  beat accept; a beat is taken when fill_valid_in && fill_ready_out.
REQ-017 fill_busy_out  output  1  high when state is not IDLE.

Function
REQ-018 Fill FSM SHALL have states IDLE, FILL and COMMIT; fill_ready_out = 1 in IDLE and FILL, 0 in COMMIT.
REQ-019 In IDLE, an accepted beat SHALL latch fill_addr_in, store the beat in slice 0, set beat count to 1 and go to FILL; if FILL_BEATS==1, it SHALL go to COMMIT instead.
REQ-020 In FILL, accepted beat k SHALL be stored in slice k (bits [(k+1)*BEAT_WDTH-1 : k*BEAT_WDTH]); the beat with k==FILL_BEATS-1 SHALL move the FSM to COMMIT; idle cycles (fill_valid_in=0) SHALL hold state and count.
REQ-021 COMMIT SHALL last exactly one cycle, write the assembled line to mem[latched address] and return to IDLE; a beat presented in COMMIT SHALL NOT be taken.
REQ-022 rd_ready_out SHALL be 0 in COMMIT and 1 otherwise, so that writes have priority and there is no same-cycle read/write.
REQ-023 For an accepted read, rd_data_out = mem[rd_addr_in] and rd_valid_out = 1 SHALL appear in the next cycle; read throughput SHALL be one read per cycle.
REQ-024 When no read is accepted, rd_valid_out SHALL be 0 and rd_data_out SHALL hold its last value.
REQ-025 A read of a line whose fill is in progress SHALL return the pre-fill contents; a read accepted in the cycle after COMMIT SHALL return the new line.
REQ-026 Writes SHALL be whole-line only; partial line writes SHALL never reach memory.

Reset
REQ-027 On reset_n low, the FSM SHALL go to IDLE, beat count to 0, rd_valid_out to 0, rd_data_out to 0 and fill_busy_out to 0.
REQ-028 The memory array SHALL NOT be reset; a reset mid-fill SHALL discard the partial line and leave memory unchanged.

Configuration
REQ-029 Macro CACHE_DATA_MEM_OUT_REG_EN SHALL, when defined, add one output register stage: read latency 2 cycles, rd_valid_out delayed to match, throughput unchanged, and the extra stage reset to 0.
REQ-030 When CACHE_DATA_MEM_OUT_REG_EN is undefined, read latency SHALL be 1 cycle per REQ-023.

Structure
REQ-031 LINE_WDTH, BEAT_WDTH and the FSM state encodings SHALL live in the shared cache configuration include.
REQ-032 Beat assembly (slice buffer, beat counter, latched address) SHALL be a sub-module named cache_line_fill_buf; the memory array and read path SHALL remain in the top module.

Verification
REQ-033 Reset, then 4 beats 0x11..,0x22..,0x33..,0x44.. to addr 5, then read addr 5 -> line = {0x44..,0x33..,0x22..,0x11..} with rd_valid_out 1 cycle after accept.
REQ-034 Fill addr 9 with gaps of 3 idle cycles between beats -> commit only after the 4th beat; fill_busy_out high throughout.
REQ-035 Read addr 9 during its fill -> old data; rd_req held through COMMIT -> rd_ready_out 0 for 1 cycle; the next read returns new data.
REQ-036 Pulse reset_n low after 2 beats to addr 3 -> addr 3 unchanged, FSM IDLE, the next fill starts from slice 0.
REQ-037 Back-to-back reads of addrs 0..7 -> 8 consecutive rd_valid_out pulses in order; repeat with CACHE_DATA_MEM_OUT_REG_EN -> same data, 2-cycle latency.
REQ-038 fill_valid_in held high across COMMIT with FILL_BEATS=1 -> exactly one beat taken per 2 cycles.
